instr_mem_responder: RTL and testbench

Memory-side responder for the processor's fetch/load/store port. It accepts one request at a time over a valid/ready handshake and models a word-organised 16-bit memory with configurable wait states. It returns read data or a write acknowledgement over a second valid/ready channel. It replaces the flat instrmem/datamem buses feeding the multicycle processor with a real request/response interface.

---
 rtl/mem_pkg.sv | 19 +
 rtl/word_ram.sv | 38 +++
 rtl/instr_mem_responder.sv | 148 ++++++++++++++
 tb/tb_instr_mem_responder.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared types, widths and address checking for the fetch/load/store responder
package mem_pkg;

   localparam int WORD_W = 16;
   localparam int CNT_W  = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_e;

   // Misaligned or beyond the array: never aliased onto a valid word.
   function automatic logic addr_err(input logic [WORD_W-1:0] addr,
                                     input int unsigned      depth_words);
      return addr[0] | (32'(addr[WORD_W-1:1]) >= depth_words);
   endfunction

endpackage

// File: rtl/word_ram.sv
// rtl/word_ram.sv - 16-bit word array, one synchronous write port and one synchronous read port
module word_ram
   import mem_pkg::*;
#(
   parameter int unsigned DEPTH = 256,
   parameter int unsigned AW    = 8
) (
   input  logic              clk,
   input  logic              we,
   input  logic [AW-1:0]     waddr,
   input  logic [WORD_W-1:0] wdata,
   input  logic              re,
   input  logic [AW-1:0]     raddr,
   output logic [WORD_W-1:0] rdata
);

   logic [WORD_W-1:0] mem [DEPTH];
   logic [WORD_W-1:0] rdata_q;
   logic [WORD_W-1:0] rdata_d;

   // Write-first: a read colliding with a write on the same edge sees the new word.
   always_comb begin
      rdata_d = rdata_q;
      if (re) begin
         rdata_d = (we && (waddr == raddr)) ? wdata : mem[raddr];
      end
   end

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
      rdata_q <= rdata_d;
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/instr_mem_responder.sv
// rtl/instr_mem_responder.sv - request/response memory responder with wait states and boot preload
module instr_mem_responder
   import mem_pkg::*;
#(
   parameter int unsigned DEPTH_WORDS = 256,
   parameter int unsigned LATENCY     = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [WORD_W-1:0] req_addr,
   input  logic [WORD_W-1:0] req_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [WORD_W-1:0] rsp_rdata,
   output logic              rsp_err,
   input  logic              ld_en,
   input  logic [WORD_W-1:0] ld_addr,
   input  logic [WORD_W-1:0] ld_data
);

   localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam logic [CNT_W-1:0] CNT_INIT = (LATENCY > 0) ? CNT_W'(LATENCY - 1) : '0;

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              we_q, we_d;
   logic [WORD_W-1:0] addr_q, addr_d;
   logic [WORD_W-1:0] wdata_q, wdata_d;
   logic              rsp_err_q, rsp_err_d;
   logic              rsp_rd_q, rsp_rd_d;

   logic              enter_resp;
   logic              acc_we;
   logic [WORD_W-1:0] acc_addr;
   logic [WORD_W-1:0] acc_wdata;
   logic              acc_err;
   logic              ld_ok;
   logic              req_store;
   logic              ram_we;
   logic [AW-1:0]     ram_waddr;
   logic [WORD_W-1:0] ram_wdata;
   logic              ram_re;
   logic [WORD_W-1:0] ram_rdata;

   // With zero wait states the access happens on the accept edge, so use the live request.
   always_comb begin
      enter_resp = ((state_q == IDLE) && req_valid && (LATENCY == 0)) ||
                   ((state_q == WAIT) && (cnt_q == '0));
      acc_we     = (state_q == IDLE) ? req_we    : we_q;
      acc_addr   = (state_q == IDLE) ? req_addr  : addr_q;
      acc_wdata  = (state_q == IDLE) ? req_wdata : wdata_q;
      acc_err    = addr_err(acc_addr, DEPTH_WORDS);
   end

   always_comb begin
      ld_ok     = rst && ld_en && (state_q == IDLE) && (32'(ld_addr) < DEPTH_WORDS);
      req_store = enter_resp && acc_we && !acc_err;
      ram_we    = req_store || ld_ok;
      ram_waddr = req_store ? acc_addr[AW:1] : ld_addr[AW-1:0];
      ram_wdata = req_store ? acc_wdata : ld_data;
      ram_re    = enter_resp && !acc_we && !acc_err;
   end

   word_ram #(
      .DEPTH (DEPTH_WORDS),
      .AW    (AW)
   ) u_word_ram (
      .clk   (clk),
      .we    (ram_we),
      .waddr (ram_waddr),
      .wdata (ram_wdata),
      .re    (ram_re),
      .raddr (acc_addr[AW:1]),
      .rdata (ram_rdata)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         we_q      <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         rsp_err_q <= 1'b0;
         rsp_rd_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         we_q      <= we_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         rsp_err_q <= rsp_err_d;
         rsp_rd_q  <= rsp_rd_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      we_d      = we_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      rsp_err_d = rsp_err_q;
      rsp_rd_d  = rsp_rd_q;
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               we_d    = req_we;
               addr_d  = req_addr;
               wdata_d = req_wdata;
               cnt_d   = CNT_INIT;
               state_d = (LATENCY > 0) ? WAIT : RESP;
            end
         end
         WAIT: begin
            if (cnt_q == '0) begin
               state_d = RESP;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         RESP: begin
            if (rsp_ready) begin
               state_d   = IDLE;
               rsp_err_d = 1'b0;
               rsp_rd_d  = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
      // rsp_rd selects RAM read data; stores and errors return zero.
      if (enter_resp) begin
         rsp_err_d = acc_err;
         rsp_rd_d  = !acc_we && !acc_err;
      end
   end

   always_comb begin
      req_ready = (state_q == IDLE);
      rsp_valid = (state_q == RESP);
      rsp_err   = rsp_err_q;
      rsp_rdata = rsp_rd_q ? ram_rdata : '0;
   end

endmodule

// File: tb/tb_instr_mem_responder.sv
// tb/tb_instr_mem_responder.sv - scoreboard bench for instr_mem_responder (LATENCY 2 and 0 builds)
module tb_instr_mem_responder;

   localparam int LAT_A = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        req_valid, req_ready, req_we, rsp_valid, rsp_ready, rsp_err, ld_en;
   logic [15:0] req_addr, req_wdata, rsp_rdata, ld_addr, ld_data;
   logic        req_valid_b, req_ready_b, req_we_b, rsp_valid_b, rsp_ready_b, rsp_err_b, ld_en_b;
   logic [15:0] req_addr_b, req_wdata_b, rsp_rdata_b, ld_addr_b, ld_data_b;

   int          n_chk = 0;
   int          n_fail = 0;
   int          cyc = 0;
   logic [16:0] exp_a[$];
   logic [16:0] exp_b[$];
   logic [16:0] ea, eb;

   instr_mem_responder #(.DEPTH_WORDS(256), .LATENCY(LAT_A)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data)
   );

   instr_mem_responder #(.DEPTH_WORDS(256), .LATENCY(0)) dut_b (
      .clk(clk), .rst(rst),
      .req_valid(req_valid_b), .req_ready(req_ready_b), .req_we(req_we_b),
      .req_addr(req_addr_b), .req_wdata(req_wdata_b),
      .rsp_valid(rsp_valid_b), .rsp_ready(rsp_ready_b), .rsp_rdata(rsp_rdata_b), .rsp_err(rsp_err_b),
      .ld_en(ld_en_b), .ld_addr(ld_addr_b), .ld_data(ld_data_b)
   );

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic fail_now(input string name);
      n_chk++;
      n_fail++;
      $display("FAIL %s at t=%0t", name, $time);
   endtask

   always @(negedge clk) begin
      if (rst && rsp_valid && rsp_ready) begin
         if (exp_a.size() == 0) fail_now("a_unexpected_rsp");
         else begin
            ea = exp_a.pop_front();
            check("a_rdata", rsp_rdata, ea[16:1]);
            check("a_err", rsp_err, ea[0]);
         end
      end
      if (rst && rsp_valid_b && rsp_ready_b) begin
         if (exp_b.size() == 0) fail_now("b_unexpected_rsp");
         else begin
            eb = exp_b.pop_front();
            check("b_rdata", rsp_rdata_b, eb[16:1]);
            check("b_err", rsp_err_b, eb[0]);
         end
      end
   end

   task automatic ld_a(input logic [15:0] a, input logic [15:0] d);
      @(posedge clk); #1;
      ld_en = 1'b1; ld_addr = a; ld_data = d;
      @(posedge clk); #1;
      ld_en = 1'b0;
   endtask

   task automatic issue_a(input logic we, input logic [15:0] a, input logic [15:0] wd,
                          input logic [15:0] exp_rd, input logic exp_err);
      int g;
      int lat;
      @(posedge clk); #1;
      req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = wd;
      g = 0;
      @(negedge clk);
      while (!req_ready && g < 40) begin
         @(negedge clk);
         g++;
      end
      if (!req_ready) begin
         fail_now("a_accept_timeout");
         req_valid = 1'b0;
         return;
      end
      exp_a.push_back({exp_rd, exp_err});
      @(posedge clk); #1;
      req_valid = 1'b0;
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!rsp_valid && lat < 40);
      check("a_latency", lat, LAT_A + 1);
      @(posedge clk); #1;
   endtask

   initial begin
      #100000;
      $display("watchdog expired at t=%0t", $time);
      $fatal(1, "bench did not finish");
   end

   initial begin
      int g, lat, acc, prev;
      logic seen;
      rst = 1'b0;
      req_valid = 0; req_we = 0; req_addr = 0; req_wdata = 0; rsp_ready = 1'b1;
      ld_en = 0; ld_addr = 0; ld_data = 0;
      req_valid_b = 0; req_we_b = 0; req_addr_b = 0; req_wdata_b = 0; rsp_ready_b = 1'b1;
      ld_en_b = 0; ld_addr_b = 0; ld_data_b = 0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_req_ready", req_ready, 1);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_rsp_rdata", rsp_rdata, 0);
      check("rst_rsp_err", rsp_err, 0);
      check("rst_b_req_ready", req_ready_b, 1);
      check("rst_b_rsp_valid", rsp_valid_b, 0);
      @(posedge clk); #1;
      rst = 1'b1;

      ld_a(16'h0000, 16'h0F0F);
      ld_a(16'h0100, 16'hDEAD);
      ld_a(16'h0010, 16'hBEEF);
      ld_a(16'h0004, 16'h5555);
      ld_a(16'h00FF, 16'h7777);
      @(posedge clk); #1;
      ld_en_b = 1'b1; ld_addr_b = 16'h0001; ld_data_b = 16'hA5A5;
      @(posedge clk); #1;
      ld_en_b = 1'b0;

      issue_a(1'b0, 16'h0020, 16'h0000, 16'hBEEF, 1'b0);
      issue_a(1'b1, 16'h0004, 16'h1234, 16'h0000, 1'b0);
      issue_a(1'b0, 16'h0004, 16'h0000, 16'h1234, 1'b0);
      issue_a(1'b0, 16'h0003, 16'h0000, 16'h0000, 1'b1);
      issue_a(1'b0, 16'h0200, 16'h0000, 16'h0000, 1'b1);
      issue_a(1'b1, 16'h0005, 16'h9999, 16'h0000, 1'b1);
      issue_a(1'b1, 16'h0200, 16'hDEAD, 16'h0000, 1'b1);
      issue_a(1'b0, 16'h0004, 16'h0000, 16'h1234, 1'b0);
      issue_a(1'b0, 16'h0000, 16'h0000, 16'h0F0F, 1'b0);
      issue_a(1'b0, 16'h01FE, 16'h0000, 16'h7777, 1'b0);

      // Backpressure with a second request waiting behind the held response.
      @(posedge clk); #1;
      rsp_ready = 1'b0; req_valid = 1'b1; req_we = 1'b0; req_addr = 16'h0020;
      @(negedge clk);
      check("bp_ready_idle", req_ready, 1);
      exp_a.push_back({16'hBEEF, 1'b0});
      @(posedge clk); #1;
      req_addr = 16'h0004;
      exp_a.push_back({16'h1234, 1'b0});
      g = 0;
      do begin
         @(negedge clk);
         g++;
      end while (!rsp_valid && g < 40);
      check("bp_rsp_seen", rsp_valid, 1);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("bp_hold_valid", rsp_valid, 1);
         check("bp_hold_rdata", rsp_rdata, 16'hBEEF);
         check("bp_hold_req_ready", req_ready, 0);
      end
      @(posedge clk); #1;
      rsp_ready = 1'b1;
      @(negedge clk);
      check("bp_hs_req_ready", req_ready, 0);
      @(negedge clk);
      check("bp_after_req_ready", req_ready, 1);
      check("bp_after_rsp_valid", rsp_valid, 0);
      @(posedge clk); #1;
      req_valid = 1'b0;
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!rsp_valid && lat < 40);
      check("bp_second_latency", lat, LAT_A + 1);
      @(posedge clk); #1;

      // Reset during WAIT of a store drops it.
      req_valid = 1'b1; req_we = 1'b1; req_addr = 16'h0008; req_wdata = 16'hAAAA;
      @(negedge clk);
      check("rst_pre_req_ready", req_ready, 1);
      @(posedge clk); #1;
      req_valid = 1'b0; req_we = 1'b0;
      @(negedge clk);
      check("rst_in_wait_req_ready", req_ready, 0);
      rst = 1'b0;
      #1;
      check("rst_async_req_ready", req_ready, 1);
      check("rst_async_rsp_valid", rsp_valid, 0);
      @(posedge clk); #1;
      rst = 1'b1;
      seen = 1'b0;
      repeat (6) begin
         @(negedge clk);
         if (rsp_valid) seen = 1'b1;
      end
      check("rst_no_rsp", seen, 0);
      issue_a(1'b0, 16'h0008, 16'h0000, 16'h5555, 1'b0);

      // LATENCY=0 build: back-to-back loads with rsp_ready tied high.
      @(posedge clk); #1;
      req_valid_b = 1'b1; req_we_b = 1'b0; req_addr_b = 16'h0002;
      prev = 0;
      for (int k = 0; k < 4; k++) begin
         g = 0;
         do begin
            @(negedge clk);
            g++;
         end while (!req_ready_b && g < 20);
         if (!req_ready_b) fail_now("b_accept_timeout");
         acc = cyc;
         exp_b.push_back({16'hA5A5, 1'b0});
         g = 0;
         do begin
            @(negedge clk);
            g++;
         end while (!rsp_valid_b && g < 20);
         check("b_accept_to_rsp", cyc - acc, 1);
         if (k > 0) check("b_rsp_spacing", cyc - prev, 2);
         prev = cyc;
      end
      @(posedge clk); #1;
      req_valid_b = 1'b0;
      repeat (4) @(posedge clk);
      @(negedge clk);
      check("a_queue_drained", exp_a.size(), 0);
      check("b_queue_drained", exp_b.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
